// File: rtl/mux_n_1_reg.sv
// Registered N:1 word mux with break-before-make channel changes and optional auto-scan (MUX_SCAN_EN).
// Latency: in_data -> out_data 1 cycle in HOLD; a channel change blanks one cycle, the new channel shows on the next.
// Backpressure: none; the consumer must take out_data on every cycle out_valid is high.
module mux_n_1_reg #(
    parameter int  CH_NUM = 4,
    parameter int  WIDTH  = 8,
    parameter int  DWELL  = 16,
    localparam int SEL_W  = $clog2(CH_NUM)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [CH_NUM*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
    input  logic                      scan_en,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    output logic                      sel_err
);

    // Channel table is padded to a power of two so any select value indexes a real entry.
    localparam int                CH_PAD  = 1 << SEL_W;
    localparam logic [SEL_W:0]    CH_LIM  = (SEL_W+1)'(CH_NUM);
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(CH_NUM - 1);

    typedef enum logic {
        HOLD   = 1'b0,
        SWITCH = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   cur_ch;
    logic [SEL_W-1:0]   cur_ch_nxt;
    logic               sel_bad;
    logic               started;
    logic [WIDTH-1:0]   ch_word [CH_PAD];

    for (genvar k = 0; k < CH_PAD; k++) begin : g_ch
        if (k < CH_NUM) begin : g_real
            assign ch_word[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_word[k] = '0;
        end
    end

    assign sel_bad = ({1'b0, sel} >= CH_LIM);

`ifdef MUX_SCAN_EN
    // Advance when the counter would reach DWELL-1, giving DWELL-1 valid cycles plus one blank per channel.
    localparam int              DW         = $clog2(DWELL);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 2);

    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_nxt;
`else
    logic unused_scan_en;
    assign unused_scan_en = scan_en;
`endif

    // Next-state: a valid load beats a scan advance; a same-channel load in HOLD only clears the dwell.
    always_comb begin
        state_nxt  = HOLD;
        cur_ch_nxt = cur_ch;
`ifdef MUX_SCAN_EN
        dwell_nxt  = dwell_cnt;
`endif
        if (sel_load && !sel_bad) begin
            if (!(state == HOLD && sel == cur_ch)) begin
                cur_ch_nxt = sel;
                state_nxt  = SWITCH;
            end
`ifdef MUX_SCAN_EN
            dwell_nxt = '0;
`endif
        end
`ifdef MUX_SCAN_EN
        else if (!scan_en) begin
            dwell_nxt = '0;
        end else if (state == HOLD) begin
            if (dwell_cnt == DWELL_LAST) begin
                cur_ch_nxt = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
                state_nxt  = SWITCH;
                dwell_nxt  = '0;
            end else begin
                dwell_nxt = dwell_cnt + 1'b1;
            end
        end
`endif
    end

    // FSM, channel and dwell registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= SWITCH;
            cur_ch <= '0;
`ifdef MUX_SCAN_EN
            dwell_cnt <= '0;
`endif
        end else begin
            state  <= state_nxt;
            cur_ch <= cur_ch_nxt;
`ifdef MUX_SCAN_EN
            dwell_cnt <= dwell_nxt;
`endif
        end
    end

    // Output stage follows the next state so a switch blanks on the load edge itself;
    // the first edge out of reset is held blank as well.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            started   <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            started <= 1'b1;
            sel_err <= sel_load && sel_bad;
            if (started && state_nxt == HOLD) begin
                out_data  <= ch_word[cur_ch_nxt];
                out_ch    <= cur_ch_nxt;
                out_valid <= 1'b1;
            end else begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
